// File: rtl/udma_pkg.sv
// Shared uDMA channel types and datasize encodings.
package udma_pkg;

   typedef logic [31:0] ch_data_t;
   typedef logic [1:0]  ch_datasize_t;

   localparam ch_datasize_t UDMA_SIZE_BYTE = 2'b00;
   localparam ch_datasize_t UDMA_SIZE_HALF = 2'b01;
   localparam ch_datasize_t UDMA_SIZE_WORD = 2'b10;

   // FIFO entry is {datasize, data}
   localparam int unsigned PACKER_ENTRY_W = 34;

   typedef enum logic {
      StAcc   = 1'b0,
      StSplit = 1'b1
   } packer_state_e;

endpackage

// File: rtl/udma_rx_packer_if.sv
// Byte intake stream plus uDMA linear RX channel (rx_out side) of the packer.
interface udma_rx_packer_if;
   import udma_pkg::*;

   logic         in_valid;
   logic [7:0]   in_data;
   logic         in_ready;
   logic         valid;
   ch_data_t     data;
   ch_datasize_t datasize;
   logic         ready;

   // Packer side: consumes bytes, produces channel transfers.
   modport slave (
      input  in_valid, in_data, ready,
      output in_ready, valid, data, datasize
   );

   // Environment side: peripheral byte source and uDMA channel sink.
   modport master (
      output in_valid, in_data, ready,
      input  in_ready, valid, data, datasize
   );

endinterface

// File: rtl/udma_packer_fifo.sv
// Output FIFO for the RX packer; head data reads as zero while empty.
module udma_packer_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 34
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             clr_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   output logic             full_o,
   output logic             empty_o,
   input  logic             pop_i,
   output logic [Width-1:0] data_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(Depth));
   assign do_pop  = pop_i && !empty_o;
   // A push into a full FIFO only lands when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign data_o  = empty_o ? '0 : mem_q[rptr_q];

   // Pointer and occupancy next-state.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (do_push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
         if (do_pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (do_push && !clr_i) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/udma_rx_packer.sv
// Packs a peripheral byte stream into little-endian uDMA words, with flush of
// partial words as half/byte transfers and a small output FIFO.
module udma_rx_packer
   import udma_pkg::*;
#(
   parameter int unsigned OUT_DEPTH = 2
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic cfg_en_i,
   input  logic cfg_clr_i,
   input  logic cfg_pack_i,
   input  logic flush_i,
   output logic flush_done_o,
   output logic busy_o,
   udma_rx_packer_if.slave rx_if
);

   packer_state_e state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [23:0]   acc_q, acc_d;
   logic          flush_pend_q, flush_pend_d;

   logic                      in_ready, accept, flush_done;
   logic                      push;
   ch_datasize_t              push_size;
   ch_data_t                  push_data;
   logic                      fifo_full, fifo_empty;
   logic [PACKER_ENTRY_W-1:0] fifo_rdata;

   // Gated by reset so the ready output drops asynchronously with rstn_i.
   assign in_ready = rstn_i && cfg_en_i && (state_q == StAcc) && !flush_pend_q && !fifo_full;
   assign accept   = rx_if.in_valid && in_ready;

   // Byte intake, flush sequencing and FIFO push selection.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      flush_pend_d = flush_pend_q;
      push         = 1'b0;
      push_size    = UDMA_SIZE_BYTE;
      push_data    = '0;
      flush_done   = 1'b0;
      if (cfg_clr_i) begin
         state_d      = StAcc;
         cnt_d        = '0;
         acc_d        = '0;
         flush_pend_d = 1'b0;
      end else begin
         if (accept) begin
            if (cfg_pack_i) begin
               unique case (cnt_q)
                  2'd0: acc_d[7:0]   = rx_if.in_data;
                  2'd1: acc_d[15:8]  = rx_if.in_data;
                  2'd2: acc_d[23:16] = rx_if.in_data;
                  default: begin
                     push      = 1'b1;
                     push_size = UDMA_SIZE_WORD;
                     push_data = {rx_if.in_data, acc_q};
                     acc_d     = '0;
                  end
               endcase
               // Wraps 3 -> 0 on the word-completing byte.
               cnt_d = cnt_q + 2'd1;
            end else begin
               push      = 1'b1;
               push_size = UDMA_SIZE_BYTE;
               push_data = {24'h0, rx_if.in_data};
            end
         end
         if (flush_i && !flush_pend_q) flush_pend_d = 1'b1;
         // Intake is closed while a flush is pending, so flush pushes never
         // collide with byte pushes.
         if (!fifo_full) begin
            unique case (state_q)
               StAcc: begin
                  if (flush_pend_q) begin
                     unique case (cnt_q)
                        2'd0: begin
                           flush_pend_d = 1'b0;
                           flush_done   = 1'b1;
                        end
                        2'd1: begin
                           push      = 1'b1;
                           push_size = UDMA_SIZE_BYTE;
                           push_data = {24'h0, acc_q[7:0]};
                           cnt_d     = '0;
                           acc_d     = '0;
                        end
                        2'd2: begin
                           push      = 1'b1;
                           push_size = UDMA_SIZE_HALF;
                           push_data = {16'h0, acc_q[15:0]};
                           cnt_d     = '0;
                           acc_d     = '0;
                        end
                        default: begin
                           push      = 1'b1;
                           push_size = UDMA_SIZE_HALF;
                           push_data = {16'h0, acc_q[15:0]};
                           state_d   = StSplit;
                        end
                     endcase
                  end
               end
               StSplit: begin
                  push      = 1'b1;
                  push_size = UDMA_SIZE_BYTE;
                  push_data = {24'h0, acc_q[23:16]};
                  cnt_d     = '0;
                  acc_d     = '0;
                  state_d   = StAcc;
               end
               default: state_d = StAcc;
            endcase
         end
      end
   end

   // Packer state registers.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= StAcc;
         cnt_q        <= '0;
         acc_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   udma_packer_fifo #(
      .Depth (OUT_DEPTH),
      .Width (PACKER_ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .clr_i   (cfg_clr_i),
      .push_i  (push),
      .data_i  ({push_size, push_data}),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .pop_i   (rx_if.valid && rx_if.ready),
      .data_o  (fifo_rdata)
   );

   assign rx_if.in_ready = in_ready;
   assign rx_if.valid    = !fifo_empty;
   assign rx_if.data     = fifo_rdata[31:0];
   assign rx_if.datasize = fifo_rdata[33:32];
   assign flush_done_o   = flush_done;
   assign busy_o         = (cnt_q != 2'd0) || flush_pend_q || !fifo_empty;

endmodule
